// File: rtl/ppu_pkg.sv
// Shared constants, pixel type and fetch FSM encoding for the PPU scan-out line fetcher.
package ppu_pkg;

  localparam int unsigned FB_W           = 400;
  localparam int unsigned FB_H           = 300;
  localparam int unsigned PIX_PER_WORD   = 2;
  localparam int unsigned WORDS_PER_LINE = FB_W / PIX_PER_WORD;
  localparam int unsigned WORD_W         = $clog2(WORDS_PER_LINE);
  localparam int unsigned LINE_W         = $clog2(FB_H);
  localparam int unsigned RAM_DEPTH      = 2 * WORDS_PER_LINE;
  localparam int unsigned RAM_IDX_W      = $clog2(RAM_DEPTH);

  typedef logic [7:0] rgb332_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  // Low byte of a memory word is the leftmost pixel.
  function automatic rgb332_t pick_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/ppu_line_ram.sv
// Double-buffered line RAM: 2 banks of WORDS_PER_LINE x 16, one write port, one synchronous read port.
module ppu_line_ram
  import ppu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [WORD_W:0]   i_waddr,
  input  logic [15:0]       i_wdata,
  input  logic [WORD_W:0]   i_raddr,
  output logic [15:0]       o_rdata
);

  logic [15:0]          r_mem [RAM_DEPTH];
  logic [15:0]          r_rdata;
  logic [RAM_IDX_W-1:0] w_widx;
  logic [RAM_IDX_W-1:0] w_ridx;

  // {bank, word} is folded onto a dense 2*WORDS_PER_LINE array.
  assign w_widx = RAM_IDX_W'(i_waddr[WORD_W-1:0])
                + (i_waddr[WORD_W] ? RAM_IDX_W'(WORDS_PER_LINE) : '0);
  assign w_ridx = RAM_IDX_W'(i_raddr[WORD_W-1:0])
                + (i_raddr[WORD_W] ? RAM_IDX_W'(WORDS_PER_LINE) : '0);

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[w_widx] <= i_wdata;
    end
    r_rdata <= r_mem[w_ridx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ppu_line_fetcher.sv
// Scan-out stage: fetches 400x300 RGB332 lines into a double-buffered RAM and emits 2x-scaled pixels.
// Optional sticky fetch-deadline flag is built when PPU_UNDERRUN_EN is defined.
module ppu_line_fetcher
  import ppu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned FB_BASE = 0,
  parameter int unsigned V_LAST  = 666
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       counterX,
  input  logic [9:0]        counterY,
  input  logic              displayactive,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic [7:0]        rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              underrun
);

  // Trigger decode
  logic              w_is_vlast;
  logic              w_is_fetch_line;
  logic              w_trig;
  logic [LINE_W-1:0] w_trig_line;
  logic [ADDR_W-1:0] w_trig_addr;

  assign w_is_vlast      = (counterY == 10'(V_LAST));
  assign w_is_fetch_line = !counterY[0] && (counterY[9:1] < 9'(FB_H - 1));
  assign w_trig          = (counterX == '0) && (w_is_vlast || w_is_fetch_line);
  assign w_trig_line     = w_is_vlast ? '0 : LINE_W'(counterY[9:1]) + LINE_W'(1);
  assign w_trig_addr     = ADDR_W'(FB_BASE) + ADDR_W'(w_trig_line) * ADDR_W'(WORDS_PER_LINE);

  // Fetch FSM and address counter
  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic              r_bank;
  logic              w_bank_next;
  logic              w_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A trigger outranks a pending ack: the running fetch is abandoned and the new line starts at once.
  always_comb begin
    w_state_next = r_state;
    w_word_next  = r_word;
    w_addr_next  = r_addr;
    w_bank_next  = r_bank;
    w_we         = 1'b0;
    if (w_trig) begin
      w_state_next = ST_REQ;
      w_word_next  = '0;
      w_addr_next  = w_trig_addr;
      w_bank_next  = w_trig_line[0];
    end else if (r_state == ST_REQ && mem_ack) begin
      w_we        = 1'b1;
      w_word_next = r_word + WORD_W'(1);
      w_addr_next = r_addr + ADDR_W'(1);
      if (r_word == WORD_W'(WORDS_PER_LINE - 1)) begin
        w_state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_addr <= '0;
      r_bank <= 1'b0;
    end else begin
      r_word <= w_word_next;
      r_addr <= w_addr_next;
      r_bank <= w_bank_next;
    end
  end

  assign mem_req  = (r_state == ST_REQ);
  assign mem_addr = r_addr;

  // Line RAM
  logic [WORD_W-1:0] w_rd_word;
  logic [15:0]       w_rd_data;

  // Columns past the line end only occur in blanking; clamp so the read stays in range.
  assign w_rd_word = (counterX[10:2] < 9'(WORDS_PER_LINE)) ? counterX[WORD_W+1:2] : '0;

  ppu_line_ram u_line_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr ({r_bank, r_word}),
    .i_wdata (mem_data),
    .i_raddr ({counterY[1], w_rd_word}),
    .o_rdata (w_rd_data)
  );

  // Output pipe: stage 1 aligns with the RAM read, stage 2 selects the byte
  logic    r_hi_d1;
  logic    r_active_d1;
  logic    r_hs_d1;
  logic    r_vs_d1;
  rgb332_t r_rgb;
  logic    r_hs_d2;
  logic    r_vs_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_d1     <= 1'b0;
      r_active_d1 <= 1'b0;
      r_hs_d1     <= 1'b1;
      r_vs_d1     <= 1'b1;
      r_rgb       <= '0;
      r_hs_d2     <= 1'b1;
      r_vs_d2     <= 1'b1;
    end else begin
      r_hi_d1     <= counterX[1];
      r_active_d1 <= displayactive;
      r_hs_d1     <= hsync_in;
      r_vs_d1     <= vsync_in;
      r_rgb       <= r_active_d1 ? pick_byte(w_rd_data, r_hi_d1) : '0;
      r_hs_d2     <= r_hs_d1;
      r_vs_d2     <= r_vs_d1;
    end
  end

  assign rgb   = r_rgb;
  assign hsync = r_hs_d2;
  assign vsync = r_vs_d2;

`ifdef PPU_UNDERRUN_EN
  logic r_underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if (w_trig && r_state != ST_IDLE) begin
      r_underrun <= 1'b1;
    end
  end

  assign underrun = r_underrun;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_line_fetcher.sv
// Self-checking bench for ppu_line_fetcher: address scoreboard on the memory port, pixel scoreboard on rgb/syncs.
module tb_ppu_line_fetcher;
  import ppu_pkg::*;

  localparam int V_LAST_TB = 666;
  localparam int WPL       = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] counterX;
  logic [9:0]  counterY;
  logic        displayactive;
  logic        hsync_in;
  logic        vsync_in;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_ack  = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic [7:0]  rgb;
  logic        hsync;
  logic        vsync;
  logic        underrun;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ppu_line_fetcher #(
    .ADDR_W  (18),
    .FB_BASE (0),
    .V_LAST  (V_LAST_TB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .counterX      (counterX),
    .counterY      (counterY),
    .displayactive (displayactive),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .rgb           (rgb),
    .hsync         (hsync),
    .vsync         (vsync),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents model; word 0 carries the documented pattern.
  function automatic logic [15:0] mdata(input int unsigned a);
    logic [7:0] lo;
    lo = 8'(a);
    if (a == 0) return 16'hBBAA;
    return {lo ^ 8'hC3, lo + 8'h01};
  endfunction

  function automatic logic [7:0] exp_pix(input int x, input int y, input bit act);
    logic [15:0] w;
    if (!act) return 8'h00;
    w = mdata((y / 2) * WPL + x / 4);
    return (((x / 2) % 2) == 1) ? w[15:8] : w[7:0];
  endfunction

  // Memory responder: 0 = never ack, 1 = always ack (even with no request), 2 = every third cycle
  int ack_mode = 0;
  int ack_ph   = 0;
  always begin
    @(posedge clk);
    #1;
    ack_ph++;
    case (ack_mode)
      1:       mem_ack = 1'b1;
      2:       mem_ack = ((ack_ph % 3) == 0);
      default: mem_ack = 1'b0;
    endcase
    mem_data = mem_ack ? mdata(int'(mem_addr)) : 16'hDEAD;
  end

  // Address scoreboard
  logic [17:0] addr_q[$];
  int          hs_count = 0;
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_req === 1'b1 && mem_ack === 1'b1) begin
      hs_count++;
      if (addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mem_addr_unexpected: got %0h expected no request", mem_addr);
      end else begin
        check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
    end
  end

  // Pixel scoreboard
  typedef struct {
    int         due;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } pexp_t;
  pexp_t pq[$];
  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].due == cyc) begin
      pexp_t e;
      e = pq.pop_front();
      check("rgb",   32'(rgb),   32'(e.rgb));
      check("hsync", 32'(hsync), 32'(e.hs));
      check("vsync", 32'(vsync), 32'(e.vs));
    end
  end

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic        act;
    logic        hs;
    logic        vs;
    logic [7:0]  exp_rgb;
    bit          wait_fetch;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mkv(input int x, input int y, input bit act,
                               input bit hs, input bit vs, input bit wf);
    vec_t v;
    v.x          = 11'(x);
    v.y          = 10'(y);
    v.act        = act;
    v.hs         = hs;
    v.vs         = vs;
    v.exp_rgb    = exp_pix(x, y, act);
    v.wait_fetch = wf;
    return v;
  endfunction

  initial begin
    int n;
    int trig_cyc;

    // Y=0 scan while line 1 is fetched into the other bank
    for (int x = 0; x < 8; x++) vt.push_back(mkv(x, 0, 1, 1, 1, 0));
    vt.push_back(mkv(800, 0, 0, 1, 1, 0));
    vt.push_back(mkv(801, 0, 0, 0, 1, 0));
    vt.push_back(mkv(802, 0, 0, 0, 1, 0));
    vt.push_back(mkv(803, 0, 0, 1, 1, 0));
    vt.push_back(mkv(804, 0, 0, 1, 0, 0));
    vt.push_back(mkv(805, 0, 0, 1, 1, 0));
    // After the fetch: line 0 repeated on Y=1, line 1 on Y=2/3
    for (int x = 0; x < 8; x++) vt.push_back(mkv(x, 1, 1, 1, 1, x == 0));
    vt.push_back(mkv(799, 1, 1, 1, 1, 0));
    for (int x = 1; x < 4; x++) vt.push_back(mkv(x, 2, 1, 1, 1, 0));
    for (int x = 4; x < 8; x++) vt.push_back(mkv(x, 3, 1, 1, 1, 0));
    vt.push_back(mkv(799, 3, 1, 1, 1, 0));
    vt.push_back(mkv(800, 3, 0, 1, 1, 0));

    rst           = 1'b1;
    counterX      = 11'd5;
    counterY      = 10'd5;
    displayactive = 1'b0;
    hsync_in      = 1'b1;
    vsync_in      = 1'b1;
    repeat (3) tick();
    check("rst_mem_req",  32'(mem_req),  32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rgb",      32'(rgb),      32'd0);
    check("rst_hsync",    32'(hsync),    32'd1);
    check("rst_vsync",    32'(vsync),    32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    tick();

    // Frame-end prefetch of line 0, ack held high throughout
    ack_mode = 1;
    tick();
    hs_count = 0;
    for (int a = 0; a < WPL; a++) addr_q.push_back(18'(a));
    counterX = 11'd0;
    counterY = 10'(V_LAST_TB);
    tick();
    counterX = 11'd5;
    n = 0;
    while (hs_count < WPL && n < 1000) begin
      tick();
      n++;
    end
    check("fetch0_acks",    32'(hs_count),      32'(WPL));
    check("fetch0_req_low", 32'(mem_req),       32'd0);
    check("fetch0_queue",   32'(addr_q.size()), 32'd0);
    repeat (3) tick();
    check("fetch0_no_extra", 32'(hs_count), 32'(WPL));
    check("underrun_clean",  32'(underrun), 32'd0);

    // Line 1 fetch with slow memory, interleaved with the pixel table
    ack_mode = 2;
    tick();
    hs_count = 0;
    for (int a = WPL; a < 2 * WPL; a++) addr_q.push_back(18'(a));
    trig_cyc = cyc;
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wait_fetch) begin
        n = 0;
        while (hs_count < WPL && n < 2000) begin
          tick();
          n++;
        end
        check("fetch1_acks",     32'(hs_count),                 32'(WPL));
        check("fetch1_queue",    32'(addr_q.size()),            32'd0);
        check("fetch1_deadline", 32'((cyc - trig_cyc) < 2112),  32'd1);
      end
      counterX      = vt[i].x;
      counterY      = vt[i].y;
      displayactive = vt[i].act;
      hsync_in      = vt[i].hs;
      vsync_in      = vt[i].vs;
      pq.push_back('{cyc + 2, vt[i].exp_rgb, vt[i].hs, vt[i].vs});
      tick();
    end
    repeat (3) tick();
    check("pixel_queue", 32'(pq.size()), 32'd0);

    // Stalled memory: next trigger aborts and restarts at the new line
    ack_mode      = 0;
    displayactive = 1'b0;
    counterX      = 11'd5;
    repeat (2) tick();
    addr_q.delete();
    counterX = 11'd0;
    counterY = 10'(V_LAST_TB);
    tick();
    counterX = 11'd5;
    tick();
    check("stall_req",  32'(mem_req),  32'd1);
    check("stall_addr", 32'(mem_addr), 32'd0);
    repeat (3) tick();
    check("stall_addr_hold",   32'(mem_addr), 32'd0);
    check("stall_no_underrun", 32'(underrun), 32'd0);
    counterX = 11'd0;
    counterY = 10'd0;
    tick();
    counterX = 11'd5;
    tick();
    check("restart_req",  32'(mem_req),  32'd1);
    check("restart_addr", 32'(mem_addr), 32'd200);
`ifdef PPU_UNDERRUN_EN
    check("underrun_set", 32'(underrun), 32'd1);
`else
    check("underrun_set", 32'(underrun), 32'd0);
`endif

    // Reset while a fetch is outstanding and the pipe carries live data
    hsync_in      = 1'b0;
    vsync_in      = 1'b0;
    displayactive = 1'b1;
    counterX      = 11'd1;
    counterY      = 10'd1;
    repeat (2) tick();
    check("pre_rst_rgb",   32'(rgb),   32'hAA);
    check("pre_rst_hsync", 32'(hsync), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_mem_req",  32'(mem_req),  32'd0);
      check("midrst_mem_addr", 32'(mem_addr), 32'd0);
      check("midrst_rgb",      32'(rgb),      32'd0);
      check("midrst_hsync",    32'(hsync),    32'd1);
      check("midrst_vsync",    32'(vsync),    32'd1);
      check("midrst_underrun", 32'(underrun), 32'd0);
    end
    rst = 1'b0;
    repeat (2) tick();
    check("post_rst_req",   32'(mem_req), 32'd0);
    check("post_rst_hsync", 32'(hsync),   32'd0);
    check("post_rst_vsync", 32'(vsync),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
